serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell adds a+b+cin LSB first, one bit per clock,
// under a three-state IDLE/RUN/DONE controller with a one-cycle done pulse.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa, opb, res, res_nxt;
  logic             cy, fa_s, fa_c;
  logic             res_lsb_unused;

  full_adder u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (cy),
    .sum  (fa_s),
    .carry(fa_c)
  );

  // Result fills from the MSB; after WIDTH shifts bit 0 holds the first sum bit.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_nxt = fa_s;
    end else begin : g_wn
      assign res_nxt = {fa_s, res[WIDTH-1:1]};
    end
  endgenerate

  assign res_lsb_unused = res[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      cy    <= 1'b0;
      res   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          opa   <= a;
          opb   <= b;
          cy    <= cin;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          res <= res_nxt;
          opa <= opa >> 1;
          opb <= opb >> 1;
          cy  <= fa_c;
          cnt <= cnt + CW'(1);
          // Final bit: publish the result on the same edge that enters DONE.
          if (cnt == LAST) begin
            state <= DONE;
            sum   <= res_nxt;
            cout  <= fa_c;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule
